// File: rtl/ann_pkg.sv
// ann_pkg: shared sizes, word/array types and loader state encoding for the neuron layer.
package ann_pkg;
  localparam int NEURON_SIZE = 4;
  localparam int WORD_SIZE = 16;
  localparam int IDX_W = NEURON_SIZE > 1 ? $clog2(NEURON_SIZE) : 1;
  localparam int LD_W = NEURON_SIZE > 1 ? $clog2(NEURON_SIZE * NEURON_SIZE) : 1;
  typedef logic [WORD_SIZE-1:0] word_t;
  typedef word_t [NEURON_SIZE-1:0] vec_t;
  typedef vec_t [NEURON_SIZE-1:0] mat_t;
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, FIRE, CAPTURE, DRAIN} loader_state_t;
endpackage

// File: rtl/layer_loader_result_serializer.sv
// result_serializer: latches the layer results once and streams them out one word per handshake.
module result_serializer
  import ann_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_n_i,
  input  logic  capture_i,
  input  logic  drain_i,
  input  vec_t  result_i,
  input  logic  m_ready_i,
  output word_t m_data_o,
  output logic  m_valid_o,
  output logic  m_last_o,
  output logic  done_o
);
  vec_t res_q, res_d;
  logic [IDX_W-1:0] k_q, k_d;
  always_comb begin
    m_valid_o = drain_i;
    m_last_o = drain_i && (k_q == IDX_W'(NEURON_SIZE - 1));
    m_data_o = drain_i ? res_q[k_q] : '0;
    done_o = m_last_o && m_ready_i;
    res_d = capture_i ? result_i : res_q;
    k_d = done_o ? '0 : (drain_i && m_ready_i) ? k_q + 1'b1 : k_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      res_q <= '0;
      k_q <= '0;
    end else begin
      res_q <= res_d;
      k_q <= k_d;
    end
  end
endmodule

// File: rtl/layer_loader.sv
// layer_loader: deserializes weights/inputs into the layer, runs a fixed enable window,
// then hands the captured results to the serializer.
module layer_loader
  import ann_pkg::*;
#(
  parameter int NEURON_LATENCY = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_i,
  input  logic                   load_w_i,
  output logic                   busy_o,
  input  word_t                  s_data_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  output logic [NEURON_SIZE-1:0] en_o,
  output mat_t                   weights_o,
  output mat_t                   x_o,
  input  vec_t                   result_i,
  output word_t                  m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_last_o
);
  localparam int FW = NEURON_LATENCY > 1 ? $clog2(NEURON_LATENCY + 1) : 1;
  loader_state_t state_q, state_d;
  logic [LD_W-1:0] ld_cnt_q, ld_cnt_d;
  logic [FW-1:0] fire_cnt_q, fire_cnt_d;
  mat_t w_q, w_d;
  vec_t x_q, x_d;
  logic [IDX_W-1:0] row, col;
  logic done;
  always_comb begin
    state_d = state_q;
    ld_cnt_d = ld_cnt_q;
    fire_cnt_d = fire_cnt_q;
    w_d = w_q;
    x_d = x_q;
    row = IDX_W'(ld_cnt_q / LD_W'(NEURON_SIZE));
    col = IDX_W'(ld_cnt_q % LD_W'(NEURON_SIZE));
    busy_o = state_q != IDLE;
    s_ready_o = state_q == LOAD_W || state_q == LOAD_X;
    en_o = state_q == FIRE ? '1 : '0;
    case (state_q)
      IDLE: if (start_i) state_d = load_w_i ? LOAD_W : LOAD_X;
      LOAD_W: if (s_valid_i) begin
        w_d[row][col] = s_data_i;
        ld_cnt_d = ld_cnt_q == LD_W'(NEURON_SIZE * NEURON_SIZE - 1) ? '0 : ld_cnt_q + 1'b1;
        state_d = ld_cnt_q == LD_W'(NEURON_SIZE * NEURON_SIZE - 1) ? LOAD_X : LOAD_W;
      end
      LOAD_X: if (s_valid_i) begin
        x_d[col] = s_data_i;
        ld_cnt_d = ld_cnt_q == LD_W'(NEURON_SIZE - 1) ? '0 : ld_cnt_q + 1'b1;
        state_d = ld_cnt_q == LD_W'(NEURON_SIZE - 1) ? FIRE : LOAD_X;
      end
      FIRE: begin
        fire_cnt_d = fire_cnt_q == FW'(NEURON_LATENCY - 1) ? '0 : fire_cnt_q + 1'b1;
        state_d = fire_cnt_q == FW'(NEURON_LATENCY - 1) ? CAPTURE : FIRE;
      end
      CAPTURE: state_d = DRAIN;
      DRAIN: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    weights_o = w_q;
    for (int i = 0; i < NEURON_SIZE; i++) x_o[i] = x_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      ld_cnt_q <= '0;
      fire_cnt_q <= '0;
      w_q <= '0;
      x_q <= '0;
    end else begin
      state_q <= state_d;
      ld_cnt_q <= ld_cnt_d;
      fire_cnt_q <= fire_cnt_d;
      w_q <= w_d;
      x_q <= x_d;
    end
  end
  result_serializer u_ser (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .capture_i(state_q == CAPTURE),
    .drain_i  (state_q == DRAIN),
    .result_i (result_i),
    .m_ready_i(m_ready_i),
    .m_data_o (m_data_o),
    .m_valid_o(m_valid_o),
    .m_last_o (m_last_o),
    .done_o   (done)
  );
endmodule

// File: tb/tb_layer_loader.sv
// tb_layer_loader: randomized and directed runs against an array-based model of the loader.
module tb_layer_loader;
  import ann_pkg::*;
  logic clk = 0, rst_n = 0, start = 0, load_w = 0, s_valid = 0, m_ready = 0;
  word_t s_data = '0;
  logic busy, s_ready, m_valid, m_last;
  word_t m_data;
  logic [NEURON_SIZE-1:0] en;
  mat_t w_o, x_o;
  vec_t res;
  int n_chk = 0, n_err = 0, cyc = 0, stub_mode = 0;
  word_t mdl_w[4][4];
  word_t mdl_x[4];
  word_t ws[16];
  word_t xs[4];

  layer_loader #(.NEURON_LATENCY(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .load_w_i(load_w), .busy_o(busy),
    .s_data_i(s_data), .s_valid_i(s_valid), .s_ready_o(s_ready), .en_o(en),
    .weights_o(w_o), .x_o(x_o), .result_i(res), .m_data_o(m_data), .m_valid_o(m_valid),
    .m_ready_i(m_ready), .m_last_o(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    res = '0;
    for (int i = 0; i < 4; i++) begin
      res[i] = 16'h0100 + 16'(i);
      if (stub_mode != 0) begin
        res[i] = '0;
        for (int j = 0; j < 4; j++) res[i] = res[i] + w_o[i][j] * x_o[i][j];
      end
    end
  end

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic word_t mdl_res(int i);
    word_t r = 16'h0100 + 16'(i);
    if (stub_mode != 0) begin
      r = '0;
      for (int j = 0; j < 4; j++) r = r + mdl_w[i][j] * mdl_x[j];
    end
    return r;
  endfunction

  function automatic mat_t exp_w();
    mat_t r;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = mdl_w[i][j];
    return r;
  endfunction

  function automatic mat_t exp_x();
    mat_t r;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) r[i][j] = mdl_x[j];
    return r;
  endfunction

  task automatic clear_model;
    for (int i = 0; i < 4; i++) begin
      mdl_x[i] = '0;
      for (int j = 0; j < 4; j++) mdl_w[i][j] = '0;
    end
  endtask

  task automatic check_idle_outputs(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_m_data"}, m_data, 0);
  endtask

  task automatic send(word_t d, bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) tick;
    s_valid = 1;
    s_data = d;
    chk("s_ready_load", s_ready, 1);
    tick;
    s_valid = 0;
  endtask

  task automatic run(bit lw, bit gaps, bit stall, bit poke);
    int e_cnt = 0, t_acc, k = 0, st = 0, lim = 0;
    logic [16:0] prev = '0;
    bit prev_stall = 0;
    start = 1;
    load_w = lw;
    tick;
    start = 0;
    load_w = 0;
    chk("busy_start", busy, 1);
    if (lw) for (int i = 0; i < 16; i++) begin
      send(ws[i], gaps);
      mdl_w[i / 4][i % 4] = ws[i];
    end
    for (int j = 0; j < 4; j++) begin
      send(xs[j], gaps);
      mdl_x[j] = xs[j];
    end
    t_acc = cyc;
    chk("s_ready_after_load", s_ready, 0);
    chk("weights_o", w_o, exp_w());
    chk("x_o", x_o, exp_x());
    while (!m_valid && lim < 20) begin
      if (en == 4'hF) e_cnt++;
      start = poke && e_cnt == 2;
      tick;
      lim++;
    end
    start = 0;
    chk("first_valid_latency", cyc - t_acc + 1, 6);
    chk("en_cycles", e_cnt, 4);
    lim = 0;
    while (k < 4 && lim < 40) begin
      if (stall && k == 1 && st < 3) begin
        m_ready = 0;
        st++;
      end else m_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = poke && k == 1;
      if (prev_stall) chk("stall_stable", {m_last, m_data}, prev);
      chk("m_valid_drain", m_valid, 1);
      if (m_ready) begin
        chk("m_data", m_data, mdl_res(k));
        chk("m_last", m_last, k == 3);
        k++;
        prev_stall = 0;
      end else begin
        prev = {m_last, m_data};
        prev_stall = 1;
      end
      tick;
      lim++;
    end
    m_ready = 0;
    start = 0;
    chk("drain_count", k, 4);
    chk("m_valid_end", m_valid, 0);
    chk("busy_end", busy, 0);
    repeat (3) begin
      tick;
      chk("busy_stays_low", busy, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    clear_model();
    rst_n = 0;
    tick;
    tick;
    rst_n = 1;
    check_idle_outputs("reset");
    chk("reset_weights", w_o, 0);
    s_valid = 1;
    chk("idle_no_consume", s_ready, 0);
    tick;
    chk("idle_stays", busy, 0);
    s_valid = 0;

    for (int i = 0; i < 16; i++) ws[i] = 16'(i);
    for (int j = 0; j < 4; j++) xs[j] = 16'h00A0 + 16'(j);
    run(1, 0, 0, 0);
    chk("w23", w_o[2][3], 16'h000B);
    chk("x12", x_o[1][2], 16'h00A2);

    for (int j = 0; j < 4; j++) xs[j] = 16'h00B0 + 16'(j);
    run(0, 0, 0, 0);
    chk("x30", x_o[3][0], 16'h00B0);
    chk("w23_kept", w_o[2][3], 16'h000B);

    for (int i = 0; i < 16; i++) ws[i] = 16'($urandom);
    for (int j = 0; j < 4; j++) xs[j] = 16'($urandom);
    run(1, 1, 1, 0);
    run(0, 1, 0, 1);

    start = 1;
    load_w = 1;
    tick;
    start = 0;
    load_w = 0;
    for (int i = 0; i < 7; i++) send(16'h1000 + 16'(i), 0);
    s_valid = 1;
    s_data = 16'h1007;
    rst_n = 0;
    tick;
    rst_n = 1;
    s_valid = 0;
    clear_model();
    check_idle_outputs("mid_reset");
    chk("mid_reset_weights", w_o, 0);
    stub_mode = 1;
    for (int j = 0; j < 4; j++) xs[j] = 16'($urandom);
    run(0, 0, 0, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) ws[i] = 16'($urandom);
      for (int j = 0; j < 4; j++) xs[j] = 16'($urandom);
      run(r == 0 ? 1'b1 : 1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
